// File: rtl/id_fwd_scoreboard_if.sv
// Bundle of the decode-stage forwarding/hazard signals.
// master: pipeline control side that drives issue/read info.
// slave : the scoreboard that resolves operands.
interface id_fwd_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32,
  parameter int NSTAGE = 3,
  parameter int NRD    = 2
);
  logic                     stall;
  logic                     flush;
  logic                     iss_valid;
  logic [REG_AW-1:0]        iss_dst_addr;
  logic                     iss_gpr_we_;
  logic                     iss_is_load;
  logic [NRD*REG_AW-1:0]    rd_addr;
  logic [NRD*DATA_W-1:0]    gpr_rd_data;
  logic [NSTAGE*DATA_W-1:0] stage_fwd_data;
  logic [NRD*DATA_W-1:0]    fwd_data;
  logic [NRD-1:0]           fwd_hit;
  logic                     ld_hazard;
  logic [3:0]               pend_cnt;

  modport master (
    output stall, flush, iss_valid, iss_dst_addr, iss_gpr_we_, iss_is_load,
           rd_addr, gpr_rd_data, stage_fwd_data,
    input  fwd_data, fwd_hit, ld_hazard, pend_cnt
  );

  modport slave (
    input  stall, flush, iss_valid, iss_dst_addr, iss_gpr_we_, iss_is_load,
           rd_addr, gpr_rd_data, stage_fwd_data,
    output fwd_data, fwd_hit, ld_hazard, pend_cnt
  );
endinterface

// File: rtl/id_fwd_scoreboard.sv
// Decode-stage forwarding and load-use hazard unit.
// Tracks in-flight GPR writes in NSTAGE destination slots (slot 0 = EX,
// slot NSTAGE-1 = oldest) and resolves NRD operand reads to the youngest
// matching in-flight result, falling back to register-file data.
// Optional: define ID_FWD_R0_ZERO_EN to hard-wire r0 to zero
// (r0 writes are not tracked, r0 reads return 0 and never hazard).
module id_fwd_scoreboard #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32,
  parameter int NSTAGE = 3,
  parameter int NRD    = 2,
  parameter int LD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  id_fwd_scoreboard_if.slave bus
);

  logic [NSTAGE-1:0]             v_q, v_d;
  logic [NSTAGE-1:0][REG_AW-1:0] dst_q, dst_d;
  logic [NSTAGE-1:0]             ld_q, ld_d;

  logic [NRD-1:0][DATA_W-1:0]    data_w;
  logic [NRD-1:0]                hit_w;
  logic [NRD-1:0]                haz_w;
  logic                          ld_hazard;
  logic                          ins;
  logic [3:0]                    cnt;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [REG_AW-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] data;
    logic              haz;

    assign ra = bus.rd_addr[p*REG_AW +: REG_AW];

    // Scan oldest to youngest so a younger match overrides older ones.
    always_comb begin
      hit  = 1'b0;
      data = bus.gpr_rd_data[p*DATA_W +: DATA_W];
      haz  = 1'b0;
      for (int k = NSTAGE-1; k >= 0; k--) begin
        if (v_q[k] && (dst_q[k] == ra)) begin
          hit  = 1'b1;
          data = bus.stage_fwd_data[k*DATA_W +: DATA_W];
          // Only the winning slot decides the hazard.
          haz  = ld_q[k] && (k < LD_LAT);
        end
      end
`ifdef ID_FWD_R0_ZERO_EN
      if (ra == '0) begin
        hit  = 1'b0;
        data = '0;
        haz  = 1'b0;
      end
`endif
    end

    assign hit_w[p]  = hit;
    assign data_w[p] = data;
    assign haz_w[p]  = haz;
  end

  assign ld_hazard = bus.iss_valid & (|haz_w);

  // A hazarded instruction is not issued, so the slot shift creates the bubble.
`ifdef ID_FWD_R0_ZERO_EN
  assign ins = bus.iss_valid & ~bus.iss_gpr_we_ & ~ld_hazard & (bus.iss_dst_addr != '0);
`else
  assign ins = bus.iss_valid & ~bus.iss_gpr_we_ & ~ld_hazard;
`endif

  // Next slot state: flush beats stall, stall holds, otherwise shift in ID.
  always_comb begin
    v_d   = v_q;
    dst_d = dst_q;
    ld_d  = ld_q;
    if (bus.flush) begin
      v_d = '0;
    end else if (!bus.stall) begin
      for (int k = NSTAGE-1; k > 0; k--) begin
        v_d[k]   = v_q[k-1];
        dst_d[k] = dst_q[k-1];
        ld_d[k]  = ld_q[k-1];
      end
      v_d[0]   = ins;
      dst_d[0] = bus.iss_dst_addr;
      ld_d[0]  = bus.iss_is_load;
    end
  end

  // Slot registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= '0;
      dst_q <= '0;
      ld_q  <= '0;
    end else begin
      v_q   <= v_d;
      dst_q <= dst_d;
      ld_q  <= ld_d;
    end
  end

  // Popcount of valid slots.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < NSTAGE; k++) cnt = cnt + {3'b000, v_q[k]};
  end

  assign bus.fwd_data  = data_w;
  assign bus.fwd_hit   = hit_w;
  assign bus.ld_hazard = ld_hazard;
  assign bus.pend_cnt  = cnt;

endmodule

// File: doc/id_fwd_scoreboard.md
Name: id_fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the decode stage; it generalises the fixed EX/MEM forwarding to NSTAGE downstream stages and NRD read ports.
- Tracks every in-flight GPR write in a shift register of destination slots that advances with the pipeline.
- Resolves each operand read to the youngest matching in-flight result, or to register-file data when nothing matches.
- Raises a load-use hazard when an operand depends on a load that has not yet produced its data.

Parameters:
- REG_AW, 5, GPR address width.
- DATA_W, 32, data word width.
- NSTAGE, 3, number of tracked downstream stages. Slot 0 is EX; slot NSTAGE-1 is the oldest. Range 1..8.
- NRD, 2, number of operand read ports. Range 1..4.
- LD_LAT, 1, number of youngest slots in which a load result is not yet forwardable. Range 0..NSTAGE.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- stall  in  1  global pipeline stall; all slots hold.
- flush  in  1  global pipeline flush; all slots invalidate.
- iss_valid  in  1  the decoded instruction in ID is valid (if_en-qualified).
- iss_dst_addr  in  REG_AW  destination register of the ID instruction.
- iss_gpr_we_  in  1  GPR write enable of the ID instruction, active-low.
- iss_is_load  in  1  the ID instruction is a load.
- rd_addr  in  NRD*REG_AW  operand addresses, port p at bits [p*REG_AW +: REG_AW].
- gpr_rd_data  in  NRD*DATA_W  register-file read data, same packing.
- stage_fwd_data  in  NSTAGE*DATA_W  result currently held by stage k, at [k*DATA_W +: DATA_W].
- fwd_data  out  NRD*DATA_W  resolved operand values.
- fwd_hit  out  NRD  the port was served from a stage rather than the register file.
- ld_hazard  out  1  load-use hazard; ID must hold and insert a bubble.
- pend_cnt  out  4  number of valid slots (0..NSTAGE).

Behaviour:
- State: per slot k there is v[k], dst[k] and ld[k]. These are registered; everything else is combinational.
- Reset (asynchronous): all v[k]=0, dst[k]=0, ld[k]=0. Consequently pend_cnt=0, ld_hazard=0, fwd_hit=0, and fwd_data equals gpr_rd_data.
- Issue qualifier: ins = iss_valid & ~iss_gpr_we_ & ~ld_hazard.
- Update priority, evaluated on each clk rising edge:
  - flush=1: all v cleared, regardless of stall.
  - else stall=1: all slots hold.
  - else shift: slot k takes slot k-1 for k≥1. Slot 0 takes v=ins, dst=iss_dst_addr, ld=iss_is_load. The oldest slot is discarded.
- Match: m[p][k] = v[k] & (dst[k]==rd_addr[p]).
- Select: for each port, the lowest-index (youngest) matching slot wins.
  - fwd_hit[p]=1 and fwd_data[p]=stage_fwd_data[k].
  - No match: fwd_hit[p]=0 and fwd_data[p]=gpr_rd_data[p].
  - Older matches are masked by younger ones.
- Hazard:
  - ld_hazard = iss_valid & OR over p of (winning slot k < LD_LAT & ld[k]=1).
  - Only the winning slot is evaluated, so a younger non-load write to the same register suppresses the hazard.
  - While ld_hazard=1, fwd_data of the hazarded port is don't-care.
  - The bubble on the next edge is automatic because ins=0 and the slots shift.
- LD_LAT=0: ld_hazard is constant 0.
- pend_cnt is the popcount of v, zero-extended to 4 bits.
- Simultaneous stall and ld_hazard: slots hold and ld_hazard remains asserted combinationally.
- Reset asserted mid-stream: slots clear immediately, without waiting for clk.

Optional Feature:
- Macro: ID_FWD_R0_ZERO_EN.
- Defined:
  - Register 0 is hard-wired to zero.
  - An issue with iss_dst_addr==0 enters slot 0 with v=0.
  - A read with rd_addr[p]==0 returns fwd_data=0 with fwd_hit=0 and never contributes to ld_hazard.
- Undefined: register 0 is tracked and forwarded like any other register.

Test Plan:
- Reset, then read r3 with gpr_rd_data=0x1111 and no issues -> fwd_data=0x1111, fwd_hit=0, pend_cnt=0.
- Issue ALU write r3 and advance one cycle, stage_fwd_data[0]=0xAAAA -> port0 reading r3 gets 0xAAAA, hit=1. Next cycle with stage1=0xBBBB -> 0xBBBB. After NSTAGE shifts -> register-file value, pend_cnt=0.
- Issue load r5 (LD_LAT=1), next cycle the ID instruction reads r5 -> ld_hazard=1. The following edge inserts a bubble (slot0 v=0). The next cycle has ld_hazard=0 and forwards stage1 data 0x5555.
- Write r7 with value A, then write r7 with value B, leaving both in flight (slots 1 and 0) -> read r7 returns slot-0 data (younger). A load in slot 1 with an ALU write in slot 0 to the same register -> no hazard.
- Hold stall=1 for 3 cycles with 2 valid slots -> slots and pend_cnt=2 unchanged. Then assert flush together with stall -> pend_cnt=0 on the next edge.
- With ID_FWD_R0_ZERO_EN: issue write r0 -> pend_cnt unchanged. Read r0 with gpr_rd_data=0xDEAD -> fwd_data=0. Without the macro -> the r0 write is tracked and forwarded.
